// File: rtl/fp_mul_pkg.sv
// Shared types and width helpers for the iterative FP multiplier.
// Used by fp_mul_seq_ctrl, its interface and the shift-add core.
package fp_mul_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MUL,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [1:0] RM_RZ  = 2'b00;
  localparam logic [1:0] RM_RU  = 2'b01;
  localparam logic [1:0] RM_RD  = 2'b10;
  localparam logic [1:0] RM_RNE = 2'b11;

  localparam logic [31:0] QNAN_S = 32'h7FC0_0000;
  localparam logic [63:0] QNAN_D = 64'h7FF8_0000_0000_0000;

  function automatic int fp_w(input bit d);
    return d ? 64 : 32;
  endfunction

  function automatic int fp_exp_w(input bit d);
    return d ? 11 : 8;
  endfunction

  function automatic int fp_man_w(input bit d);
    return d ? 53 : 24;
  endfunction

endpackage

// File: rtl/fp_mul_seq_ctrl_if.sv
// Operand/result handshake bundle for fp_mul_seq_ctrl.
// FP_MUL_RM_PORT_EN adds a per-operation rounding mode.
interface fp_mul_seq_ctrl_if
  import fp_mul_pkg::*;
#(
  parameter int W = fp_w(1'b0)
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
`ifdef FP_MUL_RM_PORT_EN
  logic [1:0]   rm;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_inexact;
  logic         flag_overflow;
  logic         flag_underflow;
  logic         flag_invalid;

`ifdef FP_MUL_RM_PORT_EN
  modport master (
    output in_valid, op_a, op_b, rm, out_ready,
    input  in_ready, out_valid, result,
    input  flag_inexact, flag_overflow,
    input  flag_underflow, flag_invalid
  );
  modport slave (
    input  in_valid, op_a, op_b, rm, out_ready,
    output in_ready, out_valid, result,
    output flag_inexact, flag_overflow,
    output flag_underflow, flag_invalid
  );
`else
  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, result,
    input  flag_inexact, flag_overflow,
    input  flag_underflow, flag_invalid
  );
  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, result,
    output flag_inexact, flag_overflow,
    output flag_underflow, flag_invalid
  );
`endif

endinterface

// File: rtl/fp_mul_shift_add.sv
// Radix-2 shift-add mantissa multiplier, one multiplier bit per cycle.
// done is high during the final iteration; prod is valid after that edge.
module fp_mul_shift_add
  import fp_mul_pkg::*;
#(
  parameter int N = fp_man_w(1'b0)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] prod
);
  localparam logic [5:0] LAST = 6'(N - 1);

  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [5:0]     cnt;
  logic           busy;

  assign done = busy & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      prod   <= '0;
      mcand  <= {{N{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 6'd1;
      if (cnt == LAST) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/fp_mul_seq_ctrl.sv
// Iterative IEEE-754 multiply sequencer: unpack, shift-add, normalise, round, pack.
// FP_MUL_RM_PORT_EN: rounding mode comes from bus.rm instead of ROUND_MODE.
module fp_mul_seq_ctrl
  import fp_mul_pkg::*;
#(
  parameter bit         IS_DOUBLE  = 1'b0,
  parameter int         W          = fp_w(IS_DOUBLE),
  parameter int         EXP_W      = fp_exp_w(IS_DOUBLE),
  parameter int         N          = fp_man_w(IS_DOUBLE),
  parameter logic [1:0] ROUND_MODE = RM_RNE
) (
  input logic clk,
  input logic rst_n,
  fp_mul_seq_ctrl_if.slave bus
);
  localparam int FW   = N - 1;
  localparam int XW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic [W-1:0] QNAN =
    W'(IS_DOUBLE ? QNAN_D : {32'h0, QNAN_S});

  state_t         state;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [1:0]     rm_r;
  logic           sign_r;
  logic [XW-1:0]  exp_r;
  logic [2*N-2:0] prod_r;
  logic           spec_r;
  logic           spec_inv_r;
  logic [W-1:0]   spec_res_r;
  logic [W-1:0]   result;
  logic [3:0]     flags;
  logic           out_valid;

  logic [EXP_W-1:0] ea, eb;
  logic [FW-1:0]    fa, fb;
  logic             a_zero, b_zero;
  logic             a_inf, b_inf;
  logic             a_nan, b_nan;
  logic             a_snan, b_snan;
  logic [N-1:0]     ma, mb;
  logic             sign_u;
  logic [XW-1:0]    exp_u;
  logic             nan_u, inf_u;
  logic             spec_u, inv_u;
  logic [W-1:0]     spec_res_u;

  assign ea = a_r[W-2:FW];
  assign eb = b_r[W-2:FW];
  assign fa = a_r[FW-1:0];
  assign fb = b_r[FW-1:0];

  // Denormals fold into zero (flush-to-zero on input).
  assign a_zero = ~|ea;
  assign b_zero = ~|eb;
  assign a_inf  = &ea & ~|fa;
  assign b_inf  = &eb & ~|fb;
  assign a_nan  = &ea & |fa;
  assign b_nan  = &eb & |fb;
  assign a_snan = a_nan & ~fa[FW-1];
  assign b_snan = b_nan & ~fb[FW-1];

  assign ma = a_zero ? '0 : {1'b1, fa};
  assign mb = b_zero ? '0 : {1'b1, fb};

  assign sign_u = a_r[W-1] ^ b_r[W-1];
  assign exp_u  = XW'(ea) + XW'(eb) - XW'(BIAS);
  assign inv_u  = a_snan | b_snan
                | (a_inf & b_zero) | (b_inf & a_zero);
  assign nan_u  = a_nan | b_nan | inv_u;
  assign inf_u  = a_inf | b_inf;
  assign spec_u = nan_u | inf_u | a_zero | b_zero;

  always_comb begin
    spec_res_u = {sign_u, {(W-1){1'b0}}};
    unique case (1'b1)
      nan_u:
        spec_res_u = QNAN;
      ~nan_u & inf_u:
        spec_res_u = {sign_u, {EXP_W{1'b1}}, {FW{1'b0}}};
      default: ;
    endcase
  end

  logic           core_done;
  logic [2*N-1:0] core_prod;

  fp_mul_shift_add #(.N(N)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state == S_UNPACK),
    .a     (ma),
    .b     (mb),
    .done  (core_done),
    .prod  (core_prod)
  );

  // prod_r holds the normalised product with the hidden bit dropped.
  logic          g, st, inc, carry;
  logic          ovf, unf, to_max;
  logic [FW-1:0] frac_f;
  logic [XW-1:0] exp_f;
  logic [W-1:0]  pack_res;
  logic [3:0]    pack_flags;

  assign g  = prod_r[N-1];
  assign st = |prod_r[N-2:0];

  always_comb begin
    inc = 1'b0;
    case (rm_r)
      RM_RNE:  inc = g & (st | prod_r[N]);
      RM_RU:   inc = ~sign_r & (g | st);
      RM_RD:   inc = sign_r & (g | st);
      default: inc = 1'b0;
    endcase
  end

  assign {carry, frac_f} = {1'b0, prod_r[2*N-2:N]} + N'(inc);
  assign exp_f  = exp_r + XW'(carry);
  assign ovf    = ~exp_f[XW-1] & (exp_f >= XW'(EMAX));
  assign unf    = exp_f[XW-1] | (exp_f == '0);
  assign to_max = (rm_r == RM_RZ)
                | ((rm_r == RM_RU) & sign_r)
                | ((rm_r == RM_RD) & ~sign_r);

  // flags packing: {invalid, overflow, underflow, inexact}
  always_comb begin
    pack_res   = {sign_r, exp_f[EXP_W-1:0], frac_f};
    pack_flags = {3'b000, g | st};
    unique case (1'b1)
      spec_r: begin
        pack_res   = spec_res_r;
        pack_flags = {spec_inv_r, 3'b000};
      end
      ~spec_r & ovf: begin
        pack_res = to_max
          ? {sign_r, {(EXP_W-1){1'b1}}, 1'b0, {FW{1'b1}}}
          : {sign_r, {EXP_W{1'b1}}, {FW{1'b0}}};
        pack_flags = 4'b0101;
      end
      ~spec_r & unf: begin
        pack_res   = {sign_r, {(W-1){1'b0}}};
        pack_flags = 4'b0011;
      end
      default: ;
    endcase
  end

  assign bus.in_ready       = (state == S_IDLE) & rst_n;
  assign bus.out_valid      = out_valid;
  assign bus.result         = result;
  assign bus.flag_invalid   = flags[3];
  assign bus.flag_overflow  = flags[2];
  assign bus.flag_underflow = flags[1];
  assign bus.flag_inexact   = flags[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      result     <= '0;
      flags      <= '0;
      a_r        <= '0;
      b_r        <= '0;
      rm_r       <= ROUND_MODE;
      sign_r     <= 1'b0;
      exp_r      <= '0;
      prod_r     <= '0;
      spec_r     <= 1'b0;
      spec_inv_r <= 1'b0;
      spec_res_r <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.in_valid & bus.in_ready) begin
            a_r   <= bus.op_a;
            b_r   <= bus.op_b;
`ifdef FP_MUL_RM_PORT_EN
            rm_r  <= bus.rm;
`else
            rm_r  <= ROUND_MODE;
`endif
            state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sign_r     <= sign_u;
          exp_r      <= exp_u;
          spec_r     <= spec_u;
          spec_inv_r <= inv_u;
          spec_res_r <= spec_res_u;
          state      <= S_MUL;
        end
        S_MUL: begin
          if (core_done) state <= S_NORM;
        end
        S_NORM: begin
          if (core_prod[2*N-1]) begin
            prod_r <= core_prod[2*N-2:0];
            exp_r  <= exp_r + XW'(1);
          end else begin
            prod_r <= {core_prod[2*N-3:0], 1'b0};
          end
          state <= S_ROUND;
        end
        S_ROUND: begin
          result    <= pack_res;
          flags     <= pack_flags;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq_ctrl.sv
// Directed bench for fp_mul_seq_ctrl (binary32): RNE, RZ and RU instances
// run in lockstep on the same operands.
module tb_fp_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;

  int errors = 0;
  int checks = 0;

  logic [31:0] res_ne, res_rz, res_ru;
  logic [3:0]  fl_ne, fl_rz, fl_ru;
  int          lat;

  always #5 clk = ~clk;

  fp_mul_seq_ctrl_if #(.W(32)) ne_if ();
  fp_mul_seq_ctrl_if #(.W(32)) rz_if ();
  fp_mul_seq_ctrl_if #(.W(32)) ru_if ();

  assign ne_if.in_valid  = in_valid;
  assign rz_if.in_valid  = in_valid;
  assign ru_if.in_valid  = in_valid;
  assign ne_if.op_a      = op_a;
  assign rz_if.op_a      = op_a;
  assign ru_if.op_a      = op_a;
  assign ne_if.op_b      = op_b;
  assign rz_if.op_b      = op_b;
  assign ru_if.op_b      = op_b;
  assign ne_if.out_ready = out_ready;
  assign rz_if.out_ready = out_ready;
  assign ru_if.out_ready = out_ready;
`ifdef FP_MUL_RM_PORT_EN
  assign ne_if.rm = 2'b11;
  assign rz_if.rm = 2'b00;
  assign ru_if.rm = 2'b01;
`endif

  fp_mul_seq_ctrl #(.IS_DOUBLE(1'b0), .ROUND_MODE(2'b11)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ne_if)
  );
  fp_mul_seq_ctrl #(.IS_DOUBLE(1'b0), .ROUND_MODE(2'b00)) dut_rz (
    .clk(clk), .rst_n(rst_n), .bus(rz_if)
  );
  fp_mul_seq_ctrl #(.IS_DOUBLE(1'b0), .ROUND_MODE(2'b01)) dut_ru (
    .clk(clk), .rst_n(rst_n), .bus(ru_if)
  );

  function automatic logic [3:0] flags_of(input logic inv,
      input logic ovf, input logic unf, input logic inx);
    return {inv, ovf, unf, inx};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    n = 0;
    while (!ne_if.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!ne_if.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res_ne = ne_if.result;
    res_rz = rz_if.result;
    res_ru = ru_if.result;
    fl_ne = flags_of(ne_if.flag_invalid, ne_if.flag_overflow,
                     ne_if.flag_underflow, ne_if.flag_inexact);
    fl_rz = flags_of(rz_if.flag_invalid, rz_if.flag_overflow,
                     rz_if.flag_underflow, rz_if.flag_inexact);
    fl_ru = flags_of(ru_if.flag_invalid, ru_if.flag_overflow,
                     ru_if.flag_underflow, ru_if.flag_inexact);
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_a = '0;
    op_b = '0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(ne_if.out_valid), 32'h0);
    chk("rst_result", ne_if.result, 32'h0);
    chk("rst_flags", 32'(flags_of(ne_if.flag_invalid,
        ne_if.flag_overflow, ne_if.flag_underflow,
        ne_if.flag_inexact)), 32'h0);
    chk("rst_in_ready_low", 32'(ne_if.in_ready), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready_rel", 32'(ne_if.in_ready), 32'h1);

    issue(32'h3FC00000, 32'h40000000);
    chk("t1_lat", 32'(lat), 32'd27);
    chk("t1_res", res_ne, 32'h40400000);
    chk("t1_flags", 32'(fl_ne), 32'h0);
    take();

    issue(32'h3F800001, 32'h3F800001);
    chk("t2_res_ne", res_ne, 32'h3F800002);
    chk("t2_flags_ne", 32'(fl_ne), 32'h1);
    chk("t2_res_ru", res_ru, 32'h3F800003);
    chk("t2_res_rz", res_rz, 32'h3F800002);
    take();

    issue(32'hBF800001, 32'h3F800001);
    chk("t2n_res_ru", res_ru, 32'hBF800002);
    chk("t2n_res_ne", res_ne, 32'hBF800002);
    take();

    issue(32'h7F7FFFFF, 32'h40000000);
    chk("t3_res_ne", res_ne, 32'h7F800000);
    chk("t3_flags_ne", 32'(fl_ne), 32'h5);
    chk("t3_res_rz", res_rz, 32'h7F7FFFFF);
    chk("t3_flags_rz", 32'(fl_rz), 32'h5);
    chk("t3_res_ru", res_ru, 32'h7F800000);
    take();

    issue(32'hFF7FFFFF, 32'h40000000);
    chk("t3n_res_ne", res_ne, 32'hFF800000);
    chk("t3n_res_ru", res_ru, 32'hFF7FFFFF);
    take();

    issue(32'h7F800000, 32'h00000000);
    chk("t4_inf0_lat", 32'(lat), 32'd27);
    chk("t4_inf0_res", res_ne, 32'h7FC00000);
    chk("t4_inf0_flags", 32'(fl_ne), 32'h8);
    take();

    issue(32'h00800000, 32'h00800000);
    chk("t4_unf_res", res_ne, 32'h00000000);
    chk("t4_unf_flags", 32'(fl_ne), 32'h3);
    take();

    issue(32'h7F800001, 32'h3F800000);
    chk("snan_res", res_ne, 32'h7FC00000);
    chk("snan_flags", 32'(fl_ne), 32'h8);
    take();

    issue(32'h7FC00001, 32'h3F800000);
    chk("qnan_res", res_ne, 32'h7FC00000);
    chk("qnan_flags", 32'(fl_ne), 32'h0);
    take();

    issue(32'hFF800000, 32'h40000000);
    chk("inf_res", res_ne, 32'hFF800000);
    chk("inf_flags", 32'(fl_ne), 32'h0);
    take();

    issue(32'h00000000, 32'hC0400000);
    chk("zero_res", res_ne, 32'h80000000);
    chk("zero_flags", 32'(fl_ne), 32'h0);
    take();

    issue(32'h00000001, 32'h40000000);
    chk("denorm_res", res_ne, 32'h00000000);
    chk("denorm_flags", 32'(fl_ne), 32'h0);
    take();

    issue(32'h3FC00000, 32'h40000000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_stall_res", ne_if.result, 32'h40400000);
      chk("t5_stall_ready", 32'(ne_if.in_ready), 32'h0);
      chk("t5_stall_valid", 32'(ne_if.out_valid), 32'h1);
    end
    take();
    chk("t5_valid_drop", 32'(ne_if.out_valid), 32'h0);
    chk("t5_ready_rise", 32'(ne_if.in_ready), 32'h1);
    issue(32'hC0000000, 32'h40400000);
    chk("t5_b2b_lat", 32'(lat), 32'd27);
    chk("t5_b2b_res", res_ne, 32'hC0C00000);
    take();

    @(negedge clk);
    op_a = 32'h3FC00000;
    op_b = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_rst_valid", 32'(ne_if.out_valid), 32'h0);
    chk("t6_rst_flags", 32'(flags_of(ne_if.flag_invalid,
        ne_if.flag_overflow, ne_if.flag_underflow,
        ne_if.flag_inexact)), 32'h0);
    chk("t6_rst_result", ne_if.result, 32'h0);
    chk("t6_rst_ready", 32'(ne_if.in_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_ready_rel", 32'(ne_if.in_ready), 32'h1);
    issue(32'h3FC00000, 32'h40000000);
    chk("t6_lat", 32'(lat), 32'd27);
    chk("t6_res", res_ne, 32'h40400000);
    chk("t6_flags", 32'(fl_ne), 32'h0);
    take();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
